// File: rtl/triangle_setup_reader.sv
// Consumer end of the triangle FIFO: pops one triangle at a time, computes twice its signed
// area and its bounding box, culls degenerate/back-facing ones and hands the rest downstream.
module triangle_setup_reader #(
  parameter int WI   = 8,
  parameter int WF   = 8,
  parameter int CNTW = 16,
  localparam int CW  = WI + WF,
  localparam int AW  = 2*CW + 3
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    fifo_empty,
  input  logic [2:0][2:0][CW-1:0] fifo_tri,
  output logic                    fifo_r_en,
  input  logic [1:0]              cull_mode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2:0][2:0][CW-1:0] out_tri,
  output logic signed [AW-1:0]    out_area,
  output logic [CW-1:0]           out_xmin,
  output logic [CW-1:0]           out_xmax,
  output logic [CW-1:0]           out_ymin,
  output logic [CW-1:0]           out_ymax,
  output logic                    busy,
  output logic [CNTW-1:0]         cnt_emitted,
  output logic [CNTW-1:0]         cnt_culled
);
  typedef enum logic [2:0] {IDLE, WAIT, CALC, CHECK, EMIT} state_t;
  state_t state, state_nxt;

  logic signed [CW-1:0]   xs [3];
  logic signed [CW-1:0]   ys [3];
  logic signed [CW:0]     dx1, dy1, dx2, dy2;
  logic signed [2*CW+1:0] p_a, p_b;
  logic signed [AW-1:0]   area;
  logic signed [CW-1:0]   xmin, xmax, ymin, ymax;
  logic                   cull;

  // Every intermediate is wide enough that no sign extension step can overflow.
  always_comb begin
    for (int v = 0; v < 3; v++) begin
      xs[v] = out_tri[v][0];
      ys[v] = out_tri[v][1];
    end
    dx1  = (CW+1)'(xs[1]) - (CW+1)'(xs[0]);
    dy1  = (CW+1)'(ys[1]) - (CW+1)'(ys[0]);
    dx2  = (CW+1)'(xs[2]) - (CW+1)'(xs[0]);
    dy2  = (CW+1)'(ys[2]) - (CW+1)'(ys[0]);
    p_a  = (2*CW+2)'(dx1) * (2*CW+2)'(dy2);
    p_b  = (2*CW+2)'(dx2) * (2*CW+2)'(dy1);
    area = AW'(p_a) - AW'(p_b);
    xmin = xs[0];
    xmax = xs[0];
    ymin = ys[0];
    ymax = ys[0];
    for (int v = 1; v < 3; v++) begin
      if (xs[v] < xmin) xmin = xs[v];
      if (xs[v] > xmax) xmax = xs[v];
      if (ys[v] < ymin) ymin = ys[v];
      if (ys[v] > ymax) ymax = ys[v];
    end
  end

  assign cull = ((cull_mode != 2'b00) && (out_area == '0)) || (cull_mode[1] && out_area[AW-1]);

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!fifo_empty) state_nxt = WAIT;
      WAIT:    state_nxt = CALC;
      CALC:    state_nxt = CHECK;
      CHECK:   if (cull) state_nxt = fifo_empty ? IDLE : WAIT;
               else      state_nxt = EMIT;
      EMIT:    if (out_ready) state_nxt = fifo_empty ? IDLE : WAIT;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    fifo_r_en = 1'b0;
    case (state)
      IDLE:    fifo_r_en = !fifo_empty;
      CHECK:   fifo_r_en = cull && !fifo_empty;
      EMIT:    fifo_r_en = out_ready && !fifo_empty;
      default: fifo_r_en = 1'b0;
    endcase
    if (Reset) fifo_r_en = 1'b0;
    out_valid = (state == EMIT);
    busy      = (state != IDLE);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      out_tri     <= '0;
      out_area    <= '0;
      out_xmin    <= '0;
      out_xmax    <= '0;
      out_ymin    <= '0;
      out_ymax    <= '0;
      cnt_emitted <= '0;
      cnt_culled  <= '0;
    end else begin
      if (state == WAIT) out_tri <= fifo_tri;
      if (state == CALC) begin
        out_area <= area;
        out_xmin <= xmin;
        out_xmax <= xmax;
        out_ymin <= ymin;
        out_ymax <= ymax;
      end
      if (state == CHECK && cull)     cnt_culled  <= cnt_culled + CNTW'(1);
      if (state == EMIT && out_ready) cnt_emitted <= cnt_emitted + CNTW'(1);
    end
  end
endmodule

// File: tb/tb_triangle_setup_reader.sv
// Bench for triangle_setup_reader: behavioural FIFO plus an arithmetic reference model of
// area, bounding box and culling, driven by directed and random triangles.
module tb_triangle_setup_reader;
  localparam int WI = 8, WF = 8, CNTW = 16;
  localparam int CW = WI + WF;
  localparam int AW = 2*CW + 3;
  typedef logic [2:0][2:0][CW-1:0] tri_t;

  logic                 Clk, Reset, fifo_empty, fifo_r_en, out_valid, out_ready, busy;
  logic [1:0]           cull_mode;
  tri_t                 fifo_tri, out_tri;
  logic signed [AW-1:0] out_area;
  logic [CW-1:0]        out_xmin, out_xmax, out_ymin, out_ymax;
  logic [CNTW-1:0]      cnt_emitted, cnt_culled;

  int checks, errors;
  int exp_emit, exp_cull;
  int cyc;

  triangle_setup_reader #(.WI(WI), .WF(WF), .CNTW(CNTW)) dut (
    .Clk(Clk), .Reset(Reset), .fifo_empty(fifo_empty), .fifo_tri(fifo_tri),
    .fifo_r_en(fifo_r_en), .cull_mode(cull_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_tri(out_tri), .out_area(out_area),
    .out_xmin(out_xmin), .out_xmax(out_xmax), .out_ymin(out_ymin), .out_ymax(out_ymax),
    .busy(busy), .cnt_emitted(cnt_emitted), .cnt_culled(cnt_culled)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end
  always @(posedge Clk) cyc <= cyc + 1;

  // FIFO model with one-cycle read latency; write pointer owned by the stimulus block.
  tri_t mem [256];
  int   wp, rp;
  assign fifo_empty = (wp == rp);
  always @(posedge Clk) begin
    if (Reset) begin
      rp       <= 0;
      fifo_tri <= '0;
    end else if (fifo_r_en && !fifo_empty) begin
      fifo_tri <= mem[rp & 255];
      rp       <= rp + 1;
    end
  end

  task automatic push(input tri_t t);
    mem[wp & 255] = t;
    wp++;
  endtask

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_tri(input string tag, input tri_t obs, input tri_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic longint crd(input tri_t t, input int v, input int c);
    return longint'($signed(t[v][c]));
  endfunction

  function automatic longint ref_area(input tri_t t);
    return (crd(t,1,0) - crd(t,0,0)) * (crd(t,2,1) - crd(t,0,1))
         - (crd(t,2,0) - crd(t,0,0)) * (crd(t,1,1) - crd(t,0,1));
  endfunction

  function automatic bit ref_cull(input longint a, input logic [1:0] m);
    if (m == 2'b00) return 1'b0;
    if (m == 2'b01) return a == 0;
    return a <= 0;
  endfunction

  function automatic longint ref_ext(input tri_t t, input int c, input bit want_max);
    longint r = crd(t, 0, c);
    for (int v = 1; v < 3; v++)
      if (want_max ? (crd(t, v, c) > r) : (crd(t, v, c) < r)) r = crd(t, v, c);
    return r;
  endfunction

  function automatic tri_t make_tri(input int x0, input int y0, input int x1, input int y1,
                                    input int x2, input int y2);
    tri_t t;
    t[0][0] = CW'(x0); t[0][1] = CW'(y0);
    t[1][0] = CW'(x1); t[1][1] = CW'(y1);
    t[2][0] = CW'(x2); t[2][1] = CW'(y2);
    for (int v = 0; v < 3; v++) t[v][2] = CW'($urandom);
    return t;
  endfunction

  task automatic chk_outputs(input string tag, input tri_t t);
    chk_tri({tag, "_tri"}, out_tri, t);
    chk({tag, "_area"}, longint'(out_area), ref_area(t));
    chk({tag, "_xmin"}, longint'($signed(out_xmin)), ref_ext(t, 0, 0));
    chk({tag, "_xmax"}, longint'($signed(out_xmax)), ref_ext(t, 0, 1));
    chk({tag, "_ymin"}, longint'($signed(out_ymin)), ref_ext(t, 1, 0));
    chk({tag, "_ymax"}, longint'($signed(out_ymax)), ref_ext(t, 1, 1));
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!out_valid && n < 20) begin
      @(negedge Clk);
      n++;
    end
    chk({tag, "_timeout"}, longint'(out_valid), 1);
  endtask

  // One triangle through an idle DUT; cull_mode holds a wrong value except during CHECK.
  task automatic run_one(input string tag, input tri_t t, input logic [1:0] mode, input int stall);
    longint a = ref_area(t);
    bit     c = ref_cull(a, mode);
    logic [1:0] junk = ~mode;
    cull_mode = junk;
    out_ready = (stall == 0);
    push(t);
    #1 chk({tag, "_ren_issue"}, longint'(fifo_r_en), 1);
    @(negedge Clk);
    chk({tag, "_ren_once"}, longint'(fifo_r_en), 0);
    @(negedge Clk);
    chk({tag, "_early_valid"}, longint'(out_valid), 0);
    @(negedge Clk);
    cull_mode = mode;
    @(negedge Clk);
    cull_mode = junk;
    if (c) begin
      exp_cull++;
      chk({tag, "_culled_valid"}, longint'(out_valid), 0);
      chk({tag, "_cnt_culled"}, longint'(cnt_culled), longint'(exp_cull % (1 << CNTW)));
      chk({tag, "_culled_busy"}, longint'(busy), 0);
    end else begin
      chk({tag, "_valid"}, longint'(out_valid), 1);
      chk_outputs(tag, t);
      for (int i = 0; i < stall; i++) begin
        @(negedge Clk);
        chk({tag, "_stall_valid"}, longint'(out_valid), 1);
        chk({tag, "_stall_area"}, longint'(out_area), a);
        chk({tag, "_stall_ren"}, longint'(fifo_r_en), 0);
      end
      out_ready = 1'b1;
      @(negedge Clk);
      exp_emit++;
      chk({tag, "_cnt_emitted"}, longint'(cnt_emitted), longint'(exp_emit % (1 << CNTW)));
      chk({tag, "_done_valid"}, longint'(out_valid), 0);
    end
  endtask

  initial begin
    tri_t   t, bp [3];
    longint held_area;
    tri_t   held_tri;
    int     last;
    bit     any_ren, any_busy;
    checks = 0; errors = 0; exp_emit = 0; exp_cull = 0;
    Reset = 1'b1; out_ready = 1'b0; cull_mode = 2'b00; wp = 0;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    chk("rst_valid", longint'(out_valid), 0);
    chk("rst_ren", longint'(fifo_r_en), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_cnt_e", longint'(cnt_emitted), 0);
    chk("rst_cnt_c", longint'(cnt_culled), 0);
    chk("rst_area", longint'(out_area), 0);
    chk("rst_xmax", longint'(out_xmax), 0);
    chk_tri("rst_tri", out_tri, '0);

    // Counter-clockwise right triangle.
    run_one("ccw", make_tri(0, 0, 'h400, 0, 0, 'h400), 2'b10, 0);
    chk("ccw_area_const", longint'(out_area), 'h100000);
    chk("ccw_xmax_const", longint'(out_xmax), 'h400);
    chk("ccw_ymin_const", longint'(out_ymin), 0);

    // Clockwise winding: culled as back-facing, then emitted with culling off.
    run_one("cw_cull", make_tri(0, 0, 0, 'h400, 'h400, 0), 2'b10, 0);
    chk("cw_area_internal", longint'(out_area), -'h100000);
    run_one("cw_keep", make_tri(0, 0, 0, 'h400, 'h400, 0), 2'b00, 0);
    chk("cw_keep_area", longint'(out_area), -'h100000);

    // Collinear.
    run_one("col_cull", make_tri(0, 0, 'h100, 'h100, 'h200, 'h200), 2'b01, 0);
    run_one("col_keep", make_tri(0, 0, 'h100, 'h100, 'h200, 'h200), 2'b00, 0);
    chk("col_area_zero", longint'(out_area), 0);

    // Negative coordinates.
    run_one("neg", make_tri(-768, -512, 'h500, -512, -768, 'h700), 2'b11, 2);
    chk("neg_xmin", longint'(out_xmin), 'hFD00);
    chk("neg_xmax", longint'(out_xmax), 'h0500);
    chk("neg_ymin", longint'(out_ymin), 'hFE00);
    chk("neg_ymax", longint'(out_ymax), 'h0700);
    chk("neg_area", longint'(out_area), 'h480000);

    // Backpressure with three queued triangles.
    cull_mode = 2'b00;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bp[k] = make_tri(k*'h100, 0, 'h300 + k*'h10, 'h40, 0, 'h200 + k*'h20);
      push(bp[k]);
    end
    @(negedge Clk);
    wait_valid("bp_first");
    held_area = longint'(out_area);
    held_tri  = out_tri;
    any_ren = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      any_ren |= fifo_r_en;
      chk("bp_hold_valid", longint'(out_valid), 1);
      chk("bp_hold_area", longint'(out_area), held_area);
      chk_tri("bp_hold_tri", out_tri, held_tri);
    end
    chk("bp_no_ren", longint'(any_ren), 0);
    out_ready = 1'b1;
    last = 0;
    for (int k = 0; k < 3; k++) begin
      wait_valid("bp_next");
      chk_outputs("bp", bp[k]);
      if (k > 0) chk("bp_spacing", longint'(cyc - last), 4);
      last = cyc;
      @(negedge Clk);
    end
    exp_emit += 3;
    chk("bp_cnt_emitted", longint'(cnt_emitted), longint'(exp_emit % (1 << CNTW)));

    // Random triangles, some made degenerate.
    for (int i = 0; i < 25; i++) begin
      t = make_tri(int'($urandom), int'($urandom), int'($urandom),
                   int'($urandom), int'($urandom), int'($urandom));
      if ($urandom_range(0, 3) == 0) t[2] = t[$urandom_range(0, 1)];
      run_one("rnd", t, 2'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    // Empty FIFO: no reads, not busy.
    any_ren = 1'b0; any_busy = 1'b0;
    repeat (8) begin
      @(negedge Clk);
      any_ren |= fifo_r_en;
      any_busy |= busy;
    end
    chk("empty_no_ren", longint'(any_ren), 0);
    chk("empty_not_busy", longint'(any_busy), 0);

    // Reset while a triangle waits in EMIT.
    cull_mode = 2'b00;
    out_ready = 1'b0;
    push(make_tri('h100, 0, 'h300, 0, 0, 'h300));
    @(negedge Clk);
    wait_valid("rst_emit");
    Reset = 1'b1;
    wp = 0;
    @(negedge Clk);
    Reset = 1'b0;
    exp_emit = 0; exp_cull = 0;
    chk("rst_emit_valid", longint'(out_valid), 0);
    chk("rst_emit_busy", longint'(busy), 0);
    chk("rst_emit_cnt_e", longint'(cnt_emitted), 0);
    chk("rst_emit_cnt_c", longint'(cnt_culled), 0);
    chk("rst_emit_area", longint'(out_area), 0);
    chk("rst_emit_ren", longint'(fifo_r_en), 0);

    // Normal operation resumes after reset.
    run_one("post_rst", make_tri(0, 0, 'h200, 0, 0, 'h100), 2'b01, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
